// File: rtl/bcd_display_scanner_if.sv
// Display scanner bus: count/blink inputs from the counter
// controller and multiplexed anode/segment drive back out.
interface bcd_display_scanner_if;
  logic        ena;
  logic [15:0] Qdata;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output ena,
    output Qdata,
    output blink,
    input  an,
    input  seg
  );

  modport slave (
    input  ena,
    input  Qdata,
    input  blink,
    output an,
    output seg
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Four-digit common-anode 7-segment scanner with tear-free
// snapshot, per-digit blink, invalid-BCD dash and zero blanking.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter bit LZB         = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  bcd_display_scanner_if.slave bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  logic [RW-1:0] cnt_q;
  logic [BW-1:0] bcnt_q;
  logic [1:0]    idx_q;
  logic          phase_q;
  logic [15:0]   shd_q;
  logic [3:0]    shb_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  logic        tick;
  logic        bwrap;
  logic        wrap;
  logic [1:0]  idx_d;
  logic        phase_d;
  logic [15:0] data_d;
  logic [3:0]  blk_d;
  logic [3:0]  nib;
  logic        lz;
  logic        blank;
  logic [6:0]  dec;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;

  assign tick    = bus.ena && (cnt_q == RMAX);
  assign bwrap   = bus.ena && (bcnt_q == BMAX);
  assign wrap    = (idx_q == 2'd3);
  assign idx_d   = idx_q + 2'd1;
  assign phase_d = phase_q ^ bwrap;
  // Digit 0 of a new pass comes straight from the bus
  assign data_d  = wrap ? bus.Qdata : shd_q;
  assign blk_d   = wrap ? bus.blink : shb_q;

  always_comb begin
    nib = data_d[3:0];
    lz  = 1'b0;
    case (idx_d)
      2'd3: begin
        nib = data_d[15:12];
        lz  = (data_d[15:12] == 4'd0);
      end
      2'd2: begin
        nib = data_d[11:8];
        lz  = (data_d[15:8] == 8'd0);
      end
      2'd1: begin
        nib = data_d[7:4];
        lz  = (data_d[15:4] == 12'd0);
      end
      default: begin
        nib = data_d[3:0];
        lz  = 1'b0;
      end
    endcase
  end

  always_comb begin
    dec = 7'b0111111;
    case (nib)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  end

  assign blank = (phase_d && blk_d[idx_d]) || (LZB && lz);
  assign an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_d);
  assign seg_d = blank ? 7'b1111111 : dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      idx_q   <= 2'd0;
      phase_q <= 1'b0;
      shd_q   <= 16'd0;
      shb_q   <= 4'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else if (bus.ena) begin
      cnt_q   <= tick ? '0 : cnt_q + RW'(1);
      bcnt_q  <= bwrap ? '0 : bcnt_q + BW'(1);
      phase_q <= phase_d;
      if (tick) begin
        idx_q <= idx_d;
        an_q  <= an_d;
        seg_q <= seg_d;
        if (wrap) begin
          shd_q <= bus.Qdata;
          shb_q <= bus.blink;
        end
      end
    end else begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule
